mult_pipe_param: RTL and testbench
==================================

MULT_PIPE_PARAM -- requirements
Module: mult_pipe_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; legal values 4, 8, 16, 32.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port in_signed  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-008 SHALL have port in_a  input  WIDTH  multiplicand.
REQ-009 SHALL have port in_b  input  WIDTH  multiplier.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  2*WIDTH  product.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the result.

Function
REQ-015 SHALL define a transfer as in_valid && in_ready on a rising edge; no other input is sampled.
REQ-016 SHALL structure the pipeline as follows; every stage carries a valid bit, tag and signed flag:
- S0: operand register.
- S1: partial-product register, WIDTH rows of 2*WIDTH bits.
- log2(WIDTH) binary adder-tree register stages.
- Output register.
REQ-017 SHALL assert out_valid exactly L = log2(WIDTH)+3 cycles after a transfer when never stalled (L=6 for WIDTH=8).
REQ-018 SHALL compute out_data as the exact product modulo 2^(2*WIDTH): unsigned when in_signed=0, two's-complement signed when in_signed=1; the mode is fixed per transaction.
REQ-019 SHALL sign-extend or correct partial products in signed mode; the MSB row is subtracted, not added.
REQ-020 SHALL sustain one transfer per cycle; bubbles (in_valid=0) propagate as invalid stages.
REQ-021 SHALL use a global stall: stall = out_valid && !out_ready; while stall=1 no stage advances and in_ready=0.
REQ-022 SHALL drive in_ready = !stall, combinationally, with no dependency on in_valid.
REQ-023 SHALL hold out_data, out_tag and out_valid stable while stalled.
REQ-024 SHALL never drop, duplicate or reorder results; results leave in transfer order.
REQ-025 SHALL drive out_data=0 and out_tag=0 whenever out_valid=0.
REQ-026 SHALL, when out_ready=1 and out_valid=1, accept the current result and advance the next one in the same cycle (no dead cycle).
REQ-027 SHALL handle simultaneous transfer-in and result-out in one cycle with no loss.
REQ-028 SHALL treat a zero operand as normal; the result is 0 with the full latency.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all stage valid bits, data and tag registers to 0 (out_valid=0, out_data=0, out_tag=0).
REQ-030 SHALL hold in_ready=1 during and after reset; in-flight operations at reset are discarded, never emitted.
REQ-031 SHALL accept a transfer on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL cover, with WIDTH=8 and out_ready=1: unsigned 255*255, tag 3 -> after 6 cycles out_data=0xFE01, out_tag=3, out_valid for 1 cycle.
REQ-033 SHALL cover, with WIDTH=8: signed -128*-128 -> 0x4000; signed -1*127 -> 0xFF81; unsigned 0xFF*0x7F -> 0x7E81; all in back-to-back cycles, results on consecutive cycles in order.
REQ-034 SHALL cover a 20 random back-to-back transfer stream with mixed modes -> 20 results, one per cycle, matching the reference model and tags.
REQ-035 SHALL cover a full pipeline with out_ready held low for 4 cycles:
- in_ready=0 and out_data held for all 4 cycles.
- On release, all in-flight results are delivered in order with none lost.
REQ-036 SHALL cover rst_n asserted with 3 operations in flight -> outputs 0 immediately; no stale result appears after release.
REQ-037 SHALL cover WIDTH=16 signed -32768*32767 -> 0xC0008000 after 7 cycles.

Source files
------------

// File: rtl/mult_pipe_param.sv
// Pipelined WIDTH x WIDTH multiplier, signed or unsigned per transaction.
// Operand register -> partial-product register -> log2(WIDTH) adder-tree
// registers -> output register. A tag travels with each operation.
// All stages advance together and freeze on a global stall.
module mult_pipe_param #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int LOG2  = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    // Leaves 0..WIDTH-1 are the partial products; node k >= WIDTH sums
    // nodes 2*(k-WIDTH) and 2*(k-WIDTH)+1, so the root is the last node.
    localparam int NODES = 2 * WIDTH - 1;

    logic               w_stall;

    logic               r_s0_vld;
    logic               r_s0_sgn;
    logic [WIDTH-1:0]   r_s0_a;
    logic [WIDTH-1:0]   r_s0_b;
    logic [TAG_W-1:0]   r_s0_tag;

    logic [PW-1:0]      w_a_ext;
    logic [PW-1:0]      w_pp [WIDTH];

    logic [PW-1:0]      r_node [NODES];
    // Index 0 tracks the partial-product stage, index LOG2 the tree root.
    logic               r_vld [0:LOG2];
    logic [TAG_W-1:0]   r_tag [0:LOG2];

    logic               r_out_vld;
    logic [PW-1:0]      r_out_data;
    logic [TAG_W-1:0]   r_out_tag;

    assign w_stall   = r_out_vld && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    // Operand stage: captures operands only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld <= 1'b0;
            r_s0_sgn <= 1'b0;
            r_s0_a   <= '0;
            r_s0_b   <= '0;
            r_s0_tag <= '0;
        end else if (!w_stall) begin
            r_s0_vld <= in_valid;
            if (in_valid) begin
                r_s0_sgn <= in_signed;
                r_s0_a   <= in_a;
                r_s0_b   <= in_b;
                r_s0_tag <= in_tag;
            end
        end
    end

    // Partial products; in signed mode the multiplier MSB row carries weight
    // -2^(WIDTH-1), so that row is negated instead of added.
    always_comb begin
        w_a_ext = r_s0_sgn ? {{WIDTH{r_s0_a[WIDTH-1]}}, r_s0_a}
                           : {{WIDTH{1'b0}}, r_s0_a};
        for (int i = 0; i < WIDTH; i++) begin
            w_pp[i] = r_s0_b[i] ? (w_a_ext << i) : '0;
        end
        if (r_s0_sgn && r_s0_b[WIDTH-1]) begin
            w_pp[WIDTH-1] = -(w_a_ext << (WIDTH - 1));
        end
    end

    // Partial-product register and binary adder tree, all levels in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NODES; k++) begin
                r_node[k] <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < WIDTH; k++) begin
                r_node[k] <= w_pp[k];
            end
            for (int k = WIDTH; k < NODES; k++) begin
                r_node[k] <= r_node[2 * (k - WIDTH)] + r_node[2 * (k - WIDTH) + 1];
            end
        end
    end

    // Valid and tag shift alongside the partial-product and tree stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LOG2; i++) begin
                r_vld[i] <= 1'b0;
                r_tag[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= r_s0_vld;
            r_tag[0] <= r_s0_tag;
            for (int i = 1; i <= LOG2; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Output register; data and tag are zeroed whenever no result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else if (!w_stall) begin
            r_out_vld  <= r_vld[LOG2];
            r_out_data <= r_vld[LOG2] ? r_node[NODES-1] : '0;
            r_out_tag  <= r_vld[LOG2] ? r_tag[LOG2] : '0;
        end
    end

endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed bench for mult_pipe_param: WIDTH=8 main instance plus a WIDTH=16
// instance. A transfer in cycle 0 yields its result in cycle L, i.e. visible
// just after the (L-1)th rising edge following the transfer edge.
module tb_mult_pipe_param;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    logic        in_valid16;
    logic        in_ready16;
    logic        in_signed16;
    logic [15:0] in_a16;
    logic [15:0] in_b16;
    logic [3:0]  in_tag16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] out_data16;
    logic [3:0]  out_tag16;

    int checks;
    int errors;

    mult_pipe_param #(.WIDTH(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    mult_pipe_param #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_signed (in_signed16),
        .in_a      (in_a16),
        .in_b      (in_b16),
        .in_tag    (in_tag16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .out_tag   (out_tag16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product: multiply after explicit zero/sign extension, mod 2^16.
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_tag    = 4'h0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b data=%h tag=%h exp rdy=1 vld=0 data=0 tag=0",
                     in_ready, out_valid, out_data, out_tag);
        end
        checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || out_data16 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state16 rdy=%b vld=%b data=%h exp 1 0 0",
                     in_ready16, out_valid16, out_data16);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    // 255*255 unsigned, tag 3, offered on the first edge after reset release.
    task automatic test_single();
        in_valid = 1'b1; in_signed = 1'b0; in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'd3;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) idle_inputs();
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL single_valid k=%0d got=%b exp=%b", k, out_valid, (k == 5));
            end
            checks++;
            if (k == 5) begin
                if (out_data !== 16'hFE01 || out_tag !== 4'd3) begin
                    errors++;
                    $display("FAIL single_result data=%h tag=%h exp data=fe01 tag=3",
                             out_data, out_tag);
                end
            end else if (out_data !== 16'h0 || out_tag !== 4'h0) begin
                errors++;
                $display("FAIL single_idle_zero k=%0d data=%h tag=%h exp 0 0", k, out_data, out_tag);
            end
        end
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_signed = 1'b1; in_a = 8'h00; in_b = 8'h5A; in_tag = 4'd7;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) idle_inputs();
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL zero_valid k=%0d got=%b exp=%b", k, out_valid, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (out_data !== 16'h0000 || out_tag !== 4'd7) begin
                    errors++;
                    $display("FAIL zero_result data=%h tag=%h exp data=0000 tag=7", out_data, out_tag);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic        vs [3];
        logic [15:0] ve [3];
        va = '{8'h80, 8'hFF, 8'hFF};
        vb = '{8'h80, 8'h7F, 8'h7F};
        vs = '{1'b1, 1'b1, 1'b0};
        ve = '{16'h4000, 16'hFF81, 16'h7E81};
        in_valid = 1'b1; in_signed = vs[0]; in_a = va[0]; in_b = vb[0]; in_tag = 4'd1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k >= 5 && k <= 7) begin
                if (out_valid !== 1'b1 || out_data !== ve[k-5] || out_tag !== 4'(k - 4)) begin
                    errors++;
                    $display("FAIL b2b_result idx=%0d vld=%b data=%h tag=%h exp vld=1 data=%h tag=%h",
                             k - 5, out_valid, out_data, out_tag, ve[k-5], 4'(k - 4));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle k=%0d vld=%b exp=0", k, out_valid);
            end
            if (k + 1 < 3) begin
                in_signed = vs[k+1]; in_a = va[k+1]; in_b = vb[k+1]; in_tag = 4'(k + 2);
            end else begin
                idle_inputs();
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0]  ra [20];
        logic [7:0]  rb [20];
        logic        rs [20];
        logic [3:0]  rt [20];
        logic [15:0] re [20];
        for (int i = 0; i < 20; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
            rs[i] = 1'($urandom_range(0, 1));
            rt[i] = 4'(i);
            re[i] = model8(ra[i], rb[i], rs[i]);
        end
        in_valid = 1'b1; in_signed = rs[0]; in_a = ra[0]; in_b = rb[0]; in_tag = rt[0];
        for (int k = 0; k <= 26; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k >= 5 && k < 25) begin
                if (out_valid !== 1'b1 || out_data !== re[k-5] || out_tag !== rt[k-5]) begin
                    errors++;
                    $display("FAIL stream_result idx=%0d vld=%b data=%h tag=%h exp vld=1 data=%h tag=%h",
                             k - 5, out_valid, out_data, out_tag, re[k-5], rt[k-5]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle k=%0d vld=%b exp=0", k, out_valid);
            end
            if (k + 1 < 20) begin
                in_signed = rs[k+1]; in_a = ra[k+1]; in_b = rb[k+1]; in_tag = rt[k+1];
            end else begin
                idle_inputs();
            end
        end
    endtask

    // Six transfers fill the pipe; out_ready is then low for four cycles while a
    // seventh operation waits at the input.
    task automatic test_stall();
        logic [7:0]  sa [7];
        logic [7:0]  sb [7];
        logic        ss [7];
        logic [15:0] se [7];
        int          vi;
        int          ei;
        sa = '{8'h03, 8'h10, 8'hFE, 8'h7F, 8'h80, 8'h80, 8'h0C};
        sb = '{8'h05, 8'h10, 8'h03, 8'h7F, 8'h01, 8'h01, 8'h0A};
        ss = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        se = '{16'h000F, 16'h0100, 16'hFFFA, 16'h3F01, 16'hFF80, 16'h0080, 16'h0078};
        out_ready = 1'b1;
        in_valid = 1'b1; in_signed = ss[0]; in_a = sa[0]; in_b = sb[0]; in_tag = 4'd1;
        for (int k = 0; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k >= 5 && k <= 9)       ei = 0;
            else if (k >= 10 && k <= 15) ei = k - 9;
            else                         ei = -1;
            checks++;
            if (ei >= 0) begin
                if (out_valid !== 1'b1 || out_data !== se[ei] || out_tag !== 4'(ei + 1)) begin
                    errors++;
                    $display("FAIL stall_result k=%0d vld=%b data=%h tag=%h exp vld=1 data=%h tag=%h",
                             k, out_valid, out_data, out_tag, se[ei], 4'(ei + 1));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_idle k=%0d vld=%b exp=0", k, out_valid);
            end
            out_ready = (k >= 5 && k <= 8) ? 1'b0 : 1'b1;
            if (k + 1 <= 5)       vi = k + 1;
            else if (k + 1 <= 10) vi = 6;
            else                  vi = -1;
            if (vi >= 0) begin
                in_valid = 1'b1; in_signed = ss[vi]; in_a = sa[vi]; in_b = sb[vi];
                in_tag = 4'(vi + 1);
            end else begin
                idle_inputs();
            end
            #1;
            checks++;
            if (in_ready !== !(k >= 5 && k <= 8)) begin
                errors++;
                $display("FAIL stall_in_ready k=%0d got=%b exp=%b", k, in_ready, !(k >= 5 && k <= 8));
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_inflight();
        logic [7:0] fa [3];
        logic [7:0] fb [3];
        fa = '{8'd2, 8'd4, 8'd6};
        fb = '{8'd3, 8'd5, 8'd7};
        in_valid = 1'b1; in_signed = 1'b0; in_a = fa[0]; in_b = fb[0]; in_tag = 4'd1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 < 3) begin
                in_a = fa[k+1]; in_b = fb[k+1]; in_tag = 4'(k + 2);
            end else begin
                idle_inputs();
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0006 || out_tag !== 4'd1) begin
            errors++;
            $display("FAIL inflight_pre vld=%b data=%h tag=%h exp vld=1 data=0006 tag=1",
                     out_valid, out_data, out_tag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inflight_async_clear vld=%b data=%h tag=%h rdy=%b exp 0 0 0 1",
                     out_valid, out_data, out_tag, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_signed = 1'b0; in_a = 8'd9; in_b = 8'd9; in_tag = 4'd9;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) idle_inputs();
            checks++;
            if (k == 5) begin
                if (out_valid !== 1'b1 || out_data !== 16'h0051 || out_tag !== 4'd9) begin
                    errors++;
                    $display("FAIL inflight_post vld=%b data=%h tag=%h exp vld=1 data=0051 tag=9",
                             out_valid, out_data, out_tag);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_stale k=%0d vld=%b data=%h exp vld=0", k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_width16();
        in_valid16 = 1'b1; in_signed16 = 1'b1; in_a16 = 16'h8000; in_b16 = 16'h7FFF;
        in_tag16 = 4'hA;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                in_valid16 = 1'b0; in_a16 = 16'h0; in_b16 = 16'h0; in_tag16 = 4'h0;
            end
            checks++;
            if (k == 6) begin
                if (out_valid16 !== 1'b1 || out_data16 !== 32'hC0008000 || out_tag16 !== 4'hA) begin
                    errors++;
                    $display("FAIL w16_result vld=%b data=%h tag=%h exp vld=1 data=c0008000 tag=a",
                             out_valid16, out_data16, out_tag16);
                end
            end else if (out_valid16 !== 1'b0) begin
                errors++;
                $display("FAIL w16_idle k=%0d vld=%b exp=0", k, out_valid16);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        out_ready16 = 1'b1;
        in_valid16  = 1'b0;
        in_signed16 = 1'b0;
        in_a16      = 16'h0;
        in_b16      = 16'h0;
        in_tag16    = 4'h0;
        idle_inputs();
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_random_stream();
        test_stall();
        test_reset_inflight();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
